// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the sequencer's control inputs and status outputs.
//   master : the controller side. It drives rom_ready, incPC, loadPC,
//            load_addr, halt_req and run, and observes the status.
//   slave  : the sequencer side. It drives pc, phase, fetch_en, exec_en,
//            halted and pc_wrap.
// ADDR_W must match the ADDR_W of the pc_sequencer that uses the interface.
interface pc_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic              rom_ready;
  logic              incPC;
  logic              loadPC;
  logic [ADDR_W-1:0] load_addr;
  logic              halt_req;
  logic              run;
  logic [ADDR_W-1:0] pc;
  logic              phase;
  logic              fetch_en;
  logic              exec_en;
  logic              halted;
  logic              pc_wrap;

  modport master (
    output rom_ready, incPC, loadPC, load_addr, halt_req, run,
    input  pc, phase, fetch_en, exec_en, halted, pc_wrap
  );

  modport slave (
    input  rom_ready, incPC, loadPC, load_addr, halt_req, run,
    output pc, phase, fetch_en, exec_en, halted, pc_wrap
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and FETCH/WAIT/EXEC/HALT instruction sequencer.
// Ports:
//   clk   - single clock; all state changes happen on its rising edge.
//   reset - asynchronous, active-low reset.
//   bus   - pc_sequencer_if.slave:
//           rom_ready, incPC, loadPC, load_addr, halt_req and run are inputs;
//           pc, phase, fetch_en, exec_en, halted and pc_wrap are outputs.
// Each instruction takes a fetch cycle, plus any ROM wait cycles, followed
// by exactly one execute cycle. pc_wrap is a sticky flag. It records that
// an increment carried out of the top bit of pc.
module pc_sequencer #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            reset,
  pc_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              wrap_q, wrap_d;
  logic              fetch_en;
  logic [ADDR_W:0]   pc_inc;

  // Modulo-2^ADDR_W increment. The MSB of the result is the carry out,
  // which is the wrap indication.
  function automatic logic [ADDR_W:0] pc_incr(input logic [ADDR_W-1:0] v);
    return {1'b0, v} + {{ADDR_W{1'b0}}, 1'b1};
  endfunction

  assign pc_inc = pc_incr(pc_q);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_VEC;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state, pc update and fetch strobe
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wrap_d   = wrap_q;
    fetch_en = 1'b0;
    case (state_q)
      S_FETCH, S_WAIT: begin
        if (bus.rom_ready) begin
          // While reset is asserted the state register shows FETCH, but no
          // instruction byte may be captured.
          fetch_en = reset;
          pc_d     = pc_inc[ADDR_W-1:0];
          wrap_d   = wrap_q | pc_inc[ADDR_W];
          state_d  = S_EXEC;
        end else begin
          state_d  = S_WAIT;
        end
      end
      S_EXEC: begin
        // A branch overrides an operand skip. A loaded target never sets
        // the wrap flag.
        if (bus.loadPC) begin
          pc_d = bus.load_addr;
        end else if (bus.incPC) begin
          pc_d   = pc_inc[ADDR_W-1:0];
          wrap_d = wrap_q | pc_inc[ADDR_W];
        end
        state_d = bus.halt_req ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (bus.run) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // phase, exec_en and halted are decoded from the registered state only,
  // so no input has a combinational path to them.
  assign bus.pc       = pc_q;
  assign bus.phase    = (state_q == S_EXEC);
  assign bus.exec_en  = (state_q == S_EXEC);
  assign bus.halted   = (state_q == S_HALT);
  assign bus.pc_wrap  = wrap_q;
  assign bus.fetch_en = fetch_en;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer.
// The driver applies one set of inputs per cycle and pushes the outputs
// the reference model expects for that cycle. The monitor pops and compares
// each entry at the falling edge.
module tb_pc_sequencer;

  localparam int ADDR_W = 12;
  localparam int NPC    = 1 << ADDR_W;

  logic clk;
  logic reset;

  pc_sequencer_if #(.ADDR_W(ADDR_W)) bus();

  pc_sequencer #(.ADDR_W(ADDR_W), .RESET_VEC(12'h000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic              phase;
    logic              fetch_en;
    logic              exec_en;
    logic              halted;
    logic              pc_wrap;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;

  // The reference model works at instruction level. It tracks whether the
  // sequencer is fetching (including ROM waits), executing or stopped.
  typedef enum {M_FETCHING, M_EXECUTING, M_STOPPED} where_t;
  where_t m_where;
  int     m_pc;
  bit     m_wrap;

  function automatic void model_reset();
    m_where = M_FETCHING;
    m_pc    = 0;
    m_wrap  = 1'b0;
  endfunction

  function automatic void model_advance(input bit rr, input bit inc, input bit ld,
                                        input int addr, input bit hr, input bit rn);
    case (m_where)
      M_FETCHING: if (rr) begin
        if (m_pc == NPC - 1) m_wrap = 1'b1;
        m_pc    = (m_pc + 1) % NPC;
        m_where = M_EXECUTING;
      end
      M_EXECUTING: begin
        if (ld) m_pc = addr;
        else if (inc) begin
          if (m_pc == NPC - 1) m_wrap = 1'b1;
          m_pc = (m_pc + 1) % NPC;
        end
        m_where = hr ? M_STOPPED : M_FETCHING;
      end
      default: if (rn) m_where = M_FETCHING;
    endcase
  endfunction

  task automatic step(input bit rst_n, input bit rr, input bit inc, input bit ld,
                      input logic [ADDR_W-1:0] addr, input bit hr, input bit rn);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst_n;
    bus.rom_ready = rr;
    bus.incPC     = inc;
    bus.loadPC    = ld;
    bus.load_addr = addr;
    bus.halt_req  = hr;
    bus.run       = rn;
    if (!rst_n) model_reset();
    e.pc       = m_pc[ADDR_W-1:0];
    e.phase    = (m_where == M_EXECUTING);
    e.exec_en  = (m_where == M_EXECUTING);
    e.halted   = (m_where == M_STOPPED);
    e.pc_wrap  = m_wrap;
    e.fetch_en = rst_n && (m_where == M_FETCHING) && rr;
    q.push_back(e);
    if (rst_n) model_advance(rr, inc, ld, int'(addr), hr, rn);
  endtask

  // Steer the sequencer into its execute cycle, then branch to addr.
  // The sequencer is left fetching at addr.
  task automatic load_to(input logic [ADDR_W-1:0] addr, input bit inc);
    for (int i = 0; i < 4; i++) begin
      if (m_where == M_EXECUTING) break;
      step(1, 1, 0, 0, '0, 0, 1);
    end
    step(1, 1, inc, 1, addr, 0, 0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (bus.pc !== e.pc || bus.phase !== e.phase || bus.fetch_en !== e.fetch_en ||
            bus.exec_en !== e.exec_en || bus.halted !== e.halted || bus.pc_wrap !== e.pc_wrap) begin
          failed++;
          $display("FAIL outputs cycle %0d: got pc=%03h ph=%0b fe=%0b ex=%0b h=%0b w=%0b, expected pc=%03h ph=%0b fe=%0b ex=%0b h=%0b w=%0b",
                   cyc, bus.pc, bus.phase, bus.fetch_en, bus.exec_en, bus.halted, bus.pc_wrap,
                   e.pc, e.phase, e.fetch_en, e.exec_en, e.halted, e.pc_wrap);
        end
      end
    end
  end

  // Driver
  initial begin
    reset         = 1'b0;
    bus.rom_ready = 1'b0;
    bus.incPC     = 1'b0;
    bus.loadPC    = 1'b0;
    bus.load_addr = '0;
    bus.halt_req  = 1'b0;
    bus.run       = 1'b0;
    model_reset();

    // Reset with rom_ready high, then a free-running fetch/execute stream.
    step(0, 1, 0, 0, '0, 0, 0);
    step(0, 1, 0, 0, '0, 0, 0);
    repeat (6) step(1, 1, 0, 0, '0, 0, 0);

    // ROM wait states at pc 005.
    load_to(12'h005, 0);
    repeat (3) step(1, 0, 0, 0, '0, 0, 0);
    step(1, 1, 0, 0, '0, 0, 0);
    step(1, 1, 0, 0, '0, 0, 0);

    // A branch takes priority over an operand skip.
    load_to(12'h3A7, 1);
    step(1, 1, 0, 0, '0, 0, 0);
    step(1, 1, 1, 0, '0, 0, 0);

    // Wrap from FFF by a fetch, and the flag stays set across a later branch.
    load_to(12'hFFF, 0);
    step(1, 1, 0, 0, '0, 0, 0);
    load_to(12'h123, 0);
    step(1, 1, 0, 0, '0, 0, 0);

    // halt_req during a fetch is ignored; during execute it halts.
    load_to(12'h040, 0);
    step(1, 1, 0, 0, '0, 1, 0);
    step(1, 1, 1, 0, '0, 1, 0);
    step(1, 1, 1, 1, 12'h777, 1, 0);
    step(1, 1, 0, 0, '0, 1, 0);
    step(1, 1, 0, 0, '0, 0, 1);
    step(1, 1, 0, 0, '0, 0, 0);
    step(1, 1, 0, 0, '0, 0, 0);

    // Asynchronous reset in the middle of a ROM wait.
    load_to(12'h0C4, 0);
    step(1, 0, 0, 0, '0, 0, 0);
    step(1, 0, 0, 0, '0, 0, 0);
    step(0, 1, 1, 1, 12'h555, 0, 0);
    step(0, 1, 0, 0, '0, 0, 0);
    step(1, 1, 0, 0, '0, 0, 0);
    step(1, 1, 0, 0, '0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [ADDR_W-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? 12'hFFF - 12'($urandom_range(0, 2))
                                       : 12'($urandom_range(0, NPC - 1));
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) == 0),
           a,
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0));
    end

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 4; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
